// File: rtl/instr_outq_pkg.sv
// Shared constants and the queued-write record for the out-register-indirect write queue.
package instr_outq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // One queued write, carried at full 16-bit width before trimming to bus widths
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } outq_entry_t;

    // Address is base plus immediate, wrapping modulo 2^16 with no carry kept
    function automatic outq_entry_t make_entry(
        input logic [15:0] offset,
        input logic [15:0] base,
        input logic [15:0] wdata
    );
        outq_entry_t e;
        e.addr = offset + base;
        e.data = wdata;
        return e;
    endfunction

endpackage

// File: rtl/instr_outq_if.sv
// Output write bus: head-of-queue address/data with a valid/ready handshake.
interface instr_outq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] outbus_addr;
    logic [DATA_W-1:0] outbus_data;
    logic              outbus_valid;
    logic              outbus_ready;

    modport master (
        output outbus_addr,
        output outbus_data,
        output outbus_valid,
        input  outbus_ready
    );

    modport slave (
        input  outbus_addr,
        input  outbus_data,
        input  outbus_valid,
        output outbus_ready
    );
endinterface

// File: rtl/instr_outq_sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    // A full queue refuses pushes even if it pops in the same cycle
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;

    // Storage write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_outq.sv
// Out-register-indirect write queue: forms (base+offset, data) writes and
// presents them in order on a valid/ready output bus.
module instr_outq
    import instr_outq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int ENT_W = ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               outrir,
    input  logic [15:0]        operand,
    input  logic [15:0]        regbus1,
    input  logic [15:0]        regbus2,
    input  logic               flush,
    output logic               stall,
    output logic [LVL_W-1:0]   level,
    output logic               ovf,
    instr_outq_if.master       outbus
);

    outq_entry_t       entry_s;
    logic [ENT_W-1:0]  wdata_s;
    logic [ENT_W-1:0]  rdata_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              ovf_r;

    assign entry_s = make_entry(operand, regbus2, regbus1);
    assign wdata_s = {entry_s.addr[ADDR_W-1:0], entry_s.data[DATA_W-1:0]};
    assign pop_s   = ~empty_s & outbus.outbus_ready;
    assign stall   = full_s;
    assign ovf     = ovf_r;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (outrir),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .empty (empty_s),
        .full  (full_s),
        .level (level)
    );

    // Sticky drop flag; a push lost to flush is intentional, not an overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (outrir && full_s && !flush) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Bus outputs are forced to zero whenever no write is presented
    always_comb begin
        outbus.outbus_valid = 1'b0;
        outbus.outbus_addr  = {ADDR_W{1'b0}};
        outbus.outbus_data  = {DATA_W{1'b0}};
        if (!empty_s) begin
            outbus.outbus_valid = 1'b1;
            outbus.outbus_addr  = rdata_s[ENT_W-1:DATA_W];
            outbus.outbus_data  = rdata_s[DATA_W-1:0];
        end else begin
            outbus.outbus_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_outq.sv
// Directed bench for instr_outq (default widths plus a 4-bit-address instance for wrap).
module tb_instr_outq;

    logic        clk;
    logic        reset;
    logic        outrir;
    logic [15:0] operand;
    logic [15:0] regbus1;
    logic [15:0] regbus2;
    logic        flush;
    logic        ready;
    logic        stall,  stall4;
    logic [2:0]  level,  level4;
    logic        ovf,    ovf4;
    int          checks;
    int          failures;

    instr_outq_if #(.ADDR_W(8), .DATA_W(8)) ob ();
    instr_outq_if #(.ADDR_W(4), .DATA_W(8)) ob4 ();

    assign ob.outbus_ready  = ready;
    assign ob4.outbus_ready = ready;

    instr_outq #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .outrir(outrir), .operand(operand),
        .regbus1(regbus1), .regbus2(regbus2), .flush(flush),
        .stall(stall), .level(level), .ovf(ovf), .outbus(ob)
    );

    instr_outq #(.ADDR_W(4), .DATA_W(8), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .outrir(outrir), .operand(operand),
        .regbus1(regbus1), .regbus2(regbus2), .flush(flush),
        .stall(stall4), .level(level4), .ovf(ovf4), .outbus(ob4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (ob.outbus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ob.outbus_valid); end
        checks++; if (ob.outbus_addr !== 8'h00 || ob.outbus_data !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h/%h exp=00/00", ob.outbus_addr, ob.outbus_data); end
        checks++; if (ovf !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf, stall); end
    endtask

    task automatic test_single();
        ready = 1'b1; operand = 16'h0010; regbus2 = 16'h0005; regbus1 = 16'h12AB; outrir = 1'b1;
        tick();
        outrir = 1'b0;
        checks++; if (ob.outbus_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ob.outbus_valid); end
        checks++; if (ob.outbus_addr !== 8'h15) begin failures++; $display("FAIL single_addr got=%h exp=15", ob.outbus_addr); end
        checks++; if (ob.outbus_data !== 8'hAB) begin failures++; $display("FAIL single_data got=%h exp=ab", ob.outbus_data); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        tick();
        checks++; if (ob.outbus_valid !== 1'b0 || ob.outbus_addr !== 8'h00 || ob.outbus_data !== 8'h00) begin
            failures++; $display("FAIL single_drain got=%b/%h/%h exp=0/00/00", ob.outbus_valid, ob.outbus_addr, ob.outbus_data); end
    endtask

    task automatic test_wrap();
        ready = 1'b0; operand = 16'hFFFF; regbus2 = 16'h0003; regbus1 = 16'h0077; outrir = 1'b1;
        tick();
        outrir = 1'b0;
        checks++; if (ob.outbus_addr !== 8'h02) begin failures++; $display("FAIL wrap_addr8 got=%h exp=02", ob.outbus_addr); end
        checks++; if (ob4.outbus_addr !== 4'h2) begin failures++; $display("FAIL wrap_addr4 got=%h exp=2", ob4.outbus_addr); end
        checks++; if (ob.outbus_data !== 8'h77) begin failures++; $display("FAIL wrap_data got=%h exp=77", ob.outbus_data); end
        ready = 1'b1;
        tick();
        checks++; if (ob.outbus_valid !== 1'b0 || ob4.outbus_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b%b exp=00", ob.outbus_valid, ob4.outbus_valid); end
        ready = 1'b0;
    endtask

    task automatic test_concurrent();
        ready = 1'b0; regbus2 = 16'h0000;
        operand = 16'h0020; regbus1 = 16'h00A1; outrir = 1'b1; tick();
        operand = 16'h0021; regbus1 = 16'h00A2; tick();
        checks++; if (level !== 3'd2 || ob.outbus_data !== 8'hA1) begin failures++; $display("FAIL conc_pre got=%0d/%h exp=2/a1", level, ob.outbus_data); end
        operand = 16'h0022; regbus1 = 16'h00A3; ready = 1'b1; tick();
        outrir = 1'b0;
        checks++; if (level !== 3'd2) begin failures++; $display("FAIL conc_level got=%0d exp=2", level); end
        checks++; if (ob.outbus_data !== 8'hA2 || ob.outbus_addr !== 8'h21) begin failures++; $display("FAIL conc_head got=%h/%h exp=21/a2", ob.outbus_addr, ob.outbus_data); end
        tick();
        checks++; if (ob.outbus_data !== 8'hA3 || ob.outbus_addr !== 8'h22 || level !== 3'd1) begin
            failures++; $display("FAIL conc_next got=%h/%h/%0d exp=22/a3/1", ob.outbus_addr, ob.outbus_data, level); end
        tick();
        checks++; if (ob.outbus_valid !== 1'b0) begin failures++; $display("FAIL conc_drain got=%b exp=0", ob.outbus_valid); end
        ready = 1'b0;
    endtask

    task automatic test_flush();
        ready = 1'b0; regbus2 = 16'h0000; outrir = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            operand = 16'(i); regbus1 = 16'h00B0 + 16'(i);
            tick();
        end
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", level); end
        tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_full got=%b exp=1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0; outrir = 1'b0;
        checks++; if (level !== 3'd0 || ob.outbus_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0d/%b exp=0/0", level, ob.outbus_valid); end
        checks++; if (ovf !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL flush_flags got=%b%b exp=00", ovf, stall); end
        tick();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_discard got=%0d exp=0", level); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0; regbus2 = 16'h0000; outrir = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            operand = 16'(i) << 4; regbus1 = 16'(i);
            tick();
            if (i == 4) begin
                checks++; if (stall !== 1'b1 || level !== 3'd4 || ovf !== 1'b0) begin
                    failures++; $display("FAIL bp_fill got=%b/%0d/%b exp=1/4/0", stall, level, ovf); end
            end
        end
        outrir = 1'b0;
        checks++; if (ovf !== 1'b1 || level !== 3'd4) begin failures++; $display("FAIL bp_drop got=%b/%0d exp=1/4", ovf, level); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (ob.outbus_valid !== 1'b1 || ob.outbus_addr !== 8'h10 || ob.outbus_data !== 8'h01) begin
                failures++; $display("FAIL hold_%0d got=%b/%h/%h exp=1/10/01", c, ob.outbus_valid, ob.outbus_addr, ob.outbus_data); end
        end
        ready = 1'b1;
        tick();
        checks++; if (stall !== 1'b0 || level !== 3'd3) begin failures++; $display("FAIL bp_unstall got=%b/%0d exp=0/3", stall, level); end
        for (int k = 2; k <= 4; k++) begin
            if (k > 2) tick();
            checks++; if (ob.outbus_data !== 8'(k) || ob.outbus_addr !== 8'(k << 4)) begin
                failures++; $display("FAIL bp_order_%0d got=%h/%h exp=%h/%h", k, ob.outbus_addr, ob.outbus_data, 8'(k << 4), 8'(k)); end
        end
        tick();
        checks++; if (ob.outbus_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL bp_drain got=%b/%0d exp=0/0", ob.outbus_valid, level); end
        tick();
        checks++; if (level !== 3'd0 || ovf !== 1'b1) begin failures++; $display("FAIL bp_idle got=%0d/%b exp=0/1", level, ovf); end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0; operand = 16'h0040; regbus2 = 16'h0000; regbus1 = 16'h00C1; outrir = 1'b1;
        tick();
        tick();
        checks++; if (level !== 3'd2 || ovf !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0d/%b exp=2/1", level, ovf); end
        reset = 1'b1; flush = 1'b1; ready = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; outrir = 1'b0; ready = 1'b0;
        checks++; if (level !== 3'd0 || ovf !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0d/%b/%b exp=0/0/0", level, ovf, stall); end
        checks++; if (ob.outbus_valid !== 1'b0 || ob.outbus_addr !== 8'h00 || ob.outbus_data !== 8'h00) begin
            failures++; $display("FAIL rst_bus got=%b/%h/%h exp=0/00/00", ob.outbus_valid, ob.outbus_addr, ob.outbus_data); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; outrir = 1'b0; flush = 1'b0; ready = 1'b0;
        operand = 16'h0000; regbus1 = 16'h0000; regbus2 = 16'h0000;
        test_reset();
        test_single();
        test_wrap();
        test_concurrent();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
